// File: rtl/uart_rx.sv
// uart_rx: 9-data-bit, no-parity UART receiver with a one-word holding register and framing/overrun flags.
// Define UART_RX_MAJORITY_EN to resolve every bit by a 2-of-3 vote over the samples around mid-bit.
module uart_rx #(
    parameter int CLK_HZ      = 25000000,
    parameter int BAUD_RATE   = 9600,
    parameter int SAMPLE_RATE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       data_ack,
    output logic [8:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);
    localparam int DIV = (CLK_HZ + BAUD_RATE * SAMPLE_RATE / 2) / (BAUD_RATE * SAMPLE_RATE);
    localparam int DW  = $clog2(DIV + 1);
    localparam int SW  = $clog2(SAMPLE_RATE);
    localparam int MID = SAMPLE_RATE / 2 - 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic          rx_meta_q, rx_sync_q, seen_high_q;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [SW-1:0] sample_cnt_q;
    logic [3:0]    bit_cnt_q;
    logic [8:0]    shift_q, data_q;
    logic          data_valid_q, framing_error_q, overrun_q, busy_q;
    logic          tick, start_det, eval, bit_val;

    assign tick      = div_cnt_q == DW'(DIV - 1);
    assign start_det = state_q == IDLE && seen_high_q && !rx_sync_q;

`ifdef UART_RX_MAJORITY_EN
    logic s_early_q, s_mid_q;

    assign eval    = tick && sample_cnt_q == SW'(MID + 1);
    assign bit_val = (s_early_q & s_mid_q) | (s_early_q & rx_sync_q) | (s_mid_q & rx_sync_q);

    // Hold the two samples that precede the voting tick
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_early_q <= 1'b1;
            s_mid_q   <= 1'b1;
        end else if (tick) begin
            if (sample_cnt_q == SW'(MID - 1)) s_early_q <= rx_sync_q;
            if (sample_cnt_q == SW'(MID)) s_mid_q <= rx_sync_q;
        end
    end
`else
    assign eval    = tick && sample_cnt_q == SW'(MID);
    assign bit_val = rx_sync_q;
`endif

    assign data          = data_q;
    assign data_valid    = data_valid_q;
    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;
    assign busy          = busy_q;

    // Divider wraps every DIV clocks and realigns to the frame on start detection
    always_comb begin
        div_cnt_d = (start_det || tick) ? '0 : div_cnt_q + DW'(1);
    end

    // Two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Sample-tick divider
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) div_cnt_q <= '0;
        else div_cnt_q <= div_cnt_d;
    end

    // Receive FSM with holding register, acknowledge handling and error flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            seen_high_q     <= 1'b0;
            sample_cnt_q    <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            data_q          <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            framing_error_q <= 1'b0;
            if (data_ack && data_valid_q) begin
                data_valid_q <= 1'b0;
                overrun_q    <= 1'b0;
            end
            if (state_q != IDLE && tick)
                sample_cnt_q <= sample_cnt_q == SW'(SAMPLE_RATE - 1) ? '0 : sample_cnt_q + SW'(1);
            case (state_q)
                IDLE: begin
                    if (rx_sync_q) seen_high_q <= 1'b1;
                    if (start_det) begin
                        state_q      <= START;
                        busy_q       <= 1'b1;
                        sample_cnt_q <= '0;
                    end
                end
                START: if (eval) begin
                    if (bit_val) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        seen_high_q <= 1'b0;
                    end else begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                    end
                end
                DATA: if (eval) begin
                    shift_q   <= {bit_val, shift_q[8:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd8) state_q <= STOP;
                end
                STOP: if (eval) begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    seen_high_q <= 1'b0;
                    if (bit_val) begin
                        data_q       <= shift_q;
                        data_valid_q <= 1'b1;
                        overrun_q    <= data_valid_q && !data_ack;
                    end else begin
                        framing_error_q <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with a frame-level reference model and randomized traffic.
module tb_uart_rx;
    // 600 kHz / (9600 * 16) = 3.906, which rounds to a 4-clock tick
    localparam int CLK_HZ = 600000;
    localparam int BAUD   = 9600;
    localparam int SR     = 16;
    localparam int DIV    = 4;
    localparam int BIT    = DIV * SR;
`ifdef UART_RX_MAJORITY_EN
    localparam int EVAL = 8;
`else
    localparam int EVAL = 7;
`endif
    // Clocks from the start-edge drive to the cycle in which the stop bit is judged
    localparam int SAME     = 2 + DIV * (EVAL + 1 + SR * 10);
    localparam int BUSY_MAX = DIV * (EVAL + 1);

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       data_ack = 1'b0;
    logic [8:0] data;
    logic       data_valid, framing_error, overrun, busy;

    int checks = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic       model_valid = 1'b0;
    logic       model_ovr = 1'b0;
    logic [8:0] model_data = '0;
    int         fe_exp = 0;

    logic       pv = 1'b0;
    logic [8:0] pd = '0;
    int         fe_cnt = 0;
    int         busy_run = 0;
    int         max_busy = 0;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .SAMPLE_RATE(SR)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rx(rx),
        .data_ack(data_ack),
        .data(data),
        .data_valid(data_valid),
        .framing_error(framing_error),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [8:0] w, input logic stop, input logic spike, input int abort);
        logic [10:0] f;
        f = {stop, w, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (i == abort) return;
            rx = f[i];
            if (spike && i >= 1 && i <= 9) begin
                idle(BIT / 2 - DIV / 2);
                rx = !f[i];
                idle(DIV);
                rx = f[i];
                idle(BIT / 2 - DIV / 2);
            end else begin
                idle(BIT);
            end
        end
    endtask

    task automatic frame(input logic [8:0] w, input logic stop, input logic spike, input logic ack_load);
        if (stop) exp_q.push_back(w);
        if (ack_load) begin
            fork
                send_frame(w, stop, spike, 11);
                begin
                    repeat (SAME) @(posedge clock);
                    #1 data_ack = 1'b1;
                    @(posedge clock);
                    #1 data_ack = 1'b0;
                end
            join
        end else begin
            send_frame(w, stop, spike, 11);
        end
        if (stop) begin
            model_ovr   = model_valid && !ack_load;
            model_valid = 1'b1;
            model_data  = w;
        end else begin
            fe_exp++;
        end
        chk("frame_valid", data_valid, model_valid);
        chk("frame_overrun", overrun, model_ovr);
        if (model_valid) chk("frame_data", data, model_data);
        chk("framing_pulses", fe_cnt, fe_exp);
    endtask

    task automatic ack_word();
        data_ack = 1'b1;
        idle(1);
        data_ack = 1'b0;
        model_valid = 1'b0;
        model_ovr   = 1'b0;
        chk("ack_valid", data_valid, model_valid);
        chk("ack_overrun", overrun, model_ovr);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_data", data, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_framing", framing_error, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                pv = 1'b0;
                pd = '0;
                busy_run = 0;
            end else begin
                if (framing_error) fe_cnt++;
                busy_run = busy ? busy_run + 1 : 0;
                if (busy_run > max_busy) max_busy = busy_run;
                if (data_valid && (!pv || data != pd)) begin
                    chk("word_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) chk("rx_word", data, exp_q.pop_front());
                end
                pv = data_valid;
                pd = data;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [8:0] w;
        logic       stop;
        idle(3);
        chk_reset_outputs();
        reset_n = 1'b1;
        idle(BIT);

        frame(9'h1A5, 1'b1, 1'b0, 1'b0);
        ack_word();

        max_busy = 0;
        rx = 1'b0;
        idle(16);
        rx = 1'b1;
        idle(2 * BIT);
        chk("glitch_busy_seen", max_busy > 0, 1);
        chk("glitch_busy_bound", max_busy <= BUSY_MAX, 1);
        chk("glitch_valid", data_valid, 0);

        frame(9'h0FF, 1'b0, 1'b0, 1'b0);
        max_busy = 0;
        idle(3 * BIT);
        chk("break_no_start", max_busy, 0);
        chk("break_framing", fe_cnt, fe_exp);
        rx = 1'b1;
        idle(BIT);
        frame(9'h05A, 1'b1, 1'b0, 1'b0);
        ack_word();

        frame(9'h001, 1'b1, 1'b0, 1'b0);
        frame(9'h155, 1'b1, 1'b0, 1'b0);
        ack_word();
        ack_word();

        frame(9'h0C3, 1'b1, 1'b0, 1'b0);
        frame(9'h13C, 1'b1, 1'b0, 1'b1);
        ack_word();

        frame(9'h0E7, 1'b1, 1'b0, 1'b0);
        send_frame(9'h12D, 1'b1, 1'b0, 5);
        rx = 1'b1;
        idle(BIT / 2);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs();
        idle(BIT);
        chk_reset_outputs();
        reset_n = 1'b1;
        model_valid = 1'b0;
        model_ovr   = 1'b0;
        idle(2 * BIT);
        chk("post_reset_valid", data_valid, 0);
        frame(9'h0AA, 1'b1, 1'b0, 1'b0);
        ack_word();

`ifdef UART_RX_MAJORITY_EN
        frame(9'h133, 1'b1, 1'b1, 1'b0);
        ack_word();
`endif

        for (int n = 0; n < 16; n++) begin
            w = 9'($urandom_range(0, 511));
            if (model_valid && w == model_data) w = w ^ 9'h001;
            stop = $urandom_range(0, 4) != 0;
            frame(w, stop, 1'b0, 1'b0);
            if (!stop) begin
                rx = 1'b1;
                idle(4);
            end
            if ($urandom_range(0, 2) != 0) ack_word();
            idle($urandom_range(4, BIT));
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 25000000, meaning the system clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 9600, meaning the serial bit rate.
REQ-003 The module SHALL have parameter SAMPLE_RATE, default 16, meaning sample ticks per bit.
REQ-004 The module SHALL have port clock, input, 1 bit: system clock; all logic is on the rising edge.
REQ-005 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port rx, input, 1 bit: serial line, idle high, asynchronous to clock.
REQ-007 The module SHALL have port data_ack, input, 1 bit: consumer acknowledges the held word.
REQ-008 The module SHALL have port data, output, 9 bits: last received word, LSB = first bit received.
REQ-009 The module SHALL have port data_valid, output, 1 bit: data holds an unacknowledged word.
REQ-010 The module SHALL have port framing_error, output, 1 bit: one-cycle pulse when a stop bit samples 0.
REQ-011 The module SHALL have port overrun, output, 1 bit: a word was overwritten before acknowledgement.
REQ-012 The module SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value only.
REQ-014 A free-running divider SHALL assert a one-cycle tick every round(CLK_HZ/(BAUD_RATE*SAMPLE_RATE)) clocks (163 at defaults; bit period 2608 clocks).
REQ-015 The divider SHALL restart from 0 on start-bit detection so that sampling is phase-aligned to the frame.
REQ-016 The frame format SHALL be 1 start bit (0), 9 data bits LSB first, 1 stop bit (1), with no parity.
REQ-017 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-018 IDLE: once the synchronized rx has been seen high, a 0 on synchronized rx SHALL move the FSM to START and clear the sample counter.
REQ-019 START: on the 8th tick (sample count 7, mid-bit), rx=0 SHALL move the FSM to DATA; rx=1 SHALL be treated as a glitch and SHALL return the FSM to IDLE with no outputs changed.
REQ-020 DATA: every 16th tick after mid-start SHALL sample one bit into a shift register (shift right, new bit into bit 8); after the 9th bit the FSM SHALL move to STOP.
REQ-021 STOP: at mid-stop, rx=1 SHALL load data from the shift register, set data_valid, and move the FSM to IDLE in the same cycle.
REQ-022 STOP: at mid-stop, rx=0 SHALL pulse framing_error for one cycle, leave data and data_valid unchanged, and return the FSM to IDLE.
REQ-023 After a framing error, IDLE SHALL wait for rx=1 before accepting a new start bit (break handling).
REQ-024 data_ack while data_valid=1 SHALL clear data_valid and overrun on the next edge; data_ack while data_valid=0 SHALL be ignored.
REQ-025 If a word completes while data_valid=1 and data_ack=0, data SHALL be overwritten and overrun set; overrun SHALL stay set until data_ack.
REQ-026 If a word completes in the same cycle as data_ack, the new word SHALL win: data_valid stays 1 and overrun is not set.
REQ-027 data SHALL be stable whenever data_valid=1 except at an overrun load.

Reset
REQ-028 While reset_n=0, the module SHALL immediately set: FSM=IDLE, data=0, data_valid=0, framing_error=0, overrun=0, busy=0, synchronizer flops=1, and divider, sample and bit counters=0.
REQ-029 Deasserting reset mid-frame SHALL discard the partial frame; reception SHALL resume at the next valid start bit after rx is seen high.

Configuration
REQ-030 With UART_RX_MAJORITY_EN defined, each bit value SHALL be the 2-of-3 majority of samples at sample counts 6, 7 and 8; this applies to start, data and stop bits.
REQ-031 Without UART_RX_MAJORITY_EN, each bit SHALL be a single sample at sample count 7.

Verification
REQ-032 Send 0x1A5 at 9600 baud, ack after valid -> data=9'h1A5, data_valid=1 about 10 bit periods after the start edge; no framing_error or overrun.
REQ-033 Drive a 1000-clock low glitch on idle rx -> FSM returns to IDLE; data_valid stays 0; busy is high for at most 1304 clocks.
REQ-034 Send 0x0FF with stop bit forced to 0 -> one-cycle framing_error; data_valid stays 0; no new frame is accepted until rx returns high.
REQ-035 Send 0x001 then 0x155 back-to-back with no ack -> data=9'h155, data_valid=1, overrun=1; ack -> both clear next cycle.
REQ-036 Assert reset_n=0 during bit 4 of a frame, release, then send 0x0AA -> only 9'h0AA is delivered; all outputs read 0 during reset.
REQ-037 With UART_RX_MAJORITY_EN defined, inject a 1-tick inverted spike at sample count 7 of each data bit of 0x133 -> data=9'h133 is received.
